capture_buffer: RTL and testbench

CAPTURE_BUFFER -- requirements
Module: capture_buffer

---
 rtl/capture_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_capture_buffer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer.sv
// -----------------------------------------------------------------------------
// capture_buffer
//
// Trigger-centred sample recorder. After an arm pulse the block records
// PRE_TRIG samples, then keeps overwriting a circular window until a qualified
// trigger sample arrives, then records enough post-trigger samples to fill the
// whole DEPTH-word memory exactly once around the trigger. The finished
// capture can be read back through an independent, always-enabled read port.
//
// Parameters
//   DATA_W    sample width in bits
//   ADDR_W    address width; DEPTH = 2**ADDR_W words
//   PRE_TRIG  samples kept before the trigger (0 .. DEPTH-1)
//
// Ports
//   clk         single clock, everything changes on the rising edge
//   rst_n       synchronous active-low reset (memory contents are kept)
//   arm         one-cycle pulse: start, or abort and restart, a capture
//   din         sample data
//   din_valid   din carries a sample this cycle
//   trig        trigger qualifier, only meaningful with din_valid
//   rd_addr     readout address
//   rd_data     registered read data, one cycle after rd_addr
//   wr_ptr      next write address
//   trig_addr   address the trigger sample was written to
//   start_addr  address of the oldest sample of the completed capture
//   wrap        one-cycle pulse after a write to address DEPTH-1
//   busy        capture in progress (PRE, ARMED or POST)
//   done        capture complete (DONE)
// -----------------------------------------------------------------------------
module capture_buffer #(
  parameter int DATA_W   = 21,
  parameter int ADDR_W   = 11,
  parameter int PRE_TRIG = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              trig,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              wrap,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  // One extra bit so a full DEPTH-sample post phase (PRE_TRIG = 0) is
  // representable without wrapping the counter.
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  PRE_LEN  = CNT_W'(PRE_TRIG);
  localparam logic [CNT_W-1:0]  POST_LEN = CNT_W'(DEPTH - PRE_TRIG);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                wrap_q, wrap_d;
  logic                wr_en;
  logic                capturing;
  logic                finish;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    cnt_d        = cnt_q;
    wr_en        = 1'b0;
    finish       = 1'b0;
    capturing    = (state_q == ST_PRE) || (state_q == ST_ARMED) ||
                   (state_q == ST_POST);
    cnt_inc      = cnt_q + CNT_ONE;

    if (arm) begin
      // Arm wins over any write or trigger presented in the same cycle.
      wr_ptr_d = '0;
      cnt_d    = '0;
      state_d  = (PRE_TRIG == 0) ? ST_ARMED : ST_PRE;
    end else if (capturing && din_valid) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      case (state_q)
        ST_PRE: begin
          // The counter is reused for the post phase, so clear it on exit.
          if (cnt_inc == PRE_LEN) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_ARMED: begin
          // No counting here: the window may wrap any number of times.
          if (trig) begin
            trig_addr_d = wr_ptr_q;
            cnt_d       = CNT_ONE;
            state_d     = ST_POST;
            // PRE_TRIG = DEPTH-1 leaves room for the trigger sample only.
            finish      = (CNT_ONE == POST_LEN);
          end
        end
        ST_POST: begin
          cnt_d  = cnt_inc;
          finish = (cnt_inc == POST_LEN);
        end
        default: ;
      endcase

      if (finish) begin
        state_d      = ST_DONE;
        // Equals the post-increment write pointer, since exactly DEPTH
        // samples surround the trigger.
        start_addr_d = trig_addr_d - PRE_OFS;
      end
    end

    wrap_d = wr_en && (&wr_ptr_q);
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      cnt_q        <= '0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      cnt_q        <= cnt_d;
      wrap_q       <= wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Simple dual-port storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset so it maps onto block RAM and a capture
  // survives a reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Read-before-write: a same-address read sees the contents prior to the
  // write on this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_data    = rd_data_q;
  assign wr_ptr     = wr_ptr_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;
  assign wrap       = wrap_q;
  assign busy       = capturing;
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_capture_buffer.sv
// -----------------------------------------------------------------------------
// tb_capture_buffer
//
// Directed bench for capture_buffer at DEPTH=16. Instance u_dut uses
// PRE_TRIG=4, instance u_dut0 uses PRE_TRIG=0. Stimulus pushes expected
// status values and expected read data into queues; a monitor on the falling
// edge pops and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_capture_buffer;

  localparam int DW = 21;
  localparam int AW = 4;

  localparam int S_WP   = 0;
  localparam int S_TA   = 1;
  localparam int S_SA   = 2;
  localparam int S_WRAP = 3;
  localparam int S_BUSY = 4;
  localparam int S_DONE = 5;
  localparam int S_RD   = 6;
  localparam int S_WCNT = 7;

  typedef struct {
    string name;
    int    dut;
    int    sig;
    int    exp;
  } stat_t;

  logic          clk;
  logic          rst_n;

  logic          arm, din_valid, trig;
  logic [DW-1:0] din;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] wr_ptr, trig_addr, start_addr;
  logic          wrap, busy, done;

  logic          arm0, din_valid0, trig0;
  logic [DW-1:0] din0;
  logic [AW-1:0] rd_addr0;
  logic [DW-1:0] rd_data0;
  logic [AW-1:0] wr_ptr0, trig_addr0, start_addr0;
  logic          wrap0, busy0, done0;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    wrap_cnt = 0;
  stat_t stat_q[$];
  int    rdq0[$];
  int    rdq1[$];
  logic  rd_req0 = 1'b0, rd_req1 = 1'b0;
  logic  rd_req0_d = 1'b0, rd_req1_d = 1'b0;
  stat_t mon_s;

  capture_buffer #(.DATA_W(DW), .ADDR_W(AW), .PRE_TRIG(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .din        (din),
    .din_valid  (din_valid),
    .trig       (trig),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_ptr     (wr_ptr),
    .trig_addr  (trig_addr),
    .start_addr (start_addr),
    .wrap       (wrap),
    .busy       (busy),
    .done       (done)
  );

  capture_buffer #(.DATA_W(DW), .ADDR_W(AW), .PRE_TRIG(0)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm0),
    .din        (din0),
    .din_valid  (din_valid0),
    .trig       (trig0),
    .rd_addr    (rd_addr0),
    .rd_data    (rd_data0),
    .wr_ptr     (wr_ptr0),
    .trig_addr  (trig_addr0),
    .start_addr (start_addr0),
    .wrap       (wrap0),
    .busy       (busy0),
    .done       (done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] actual(input int dut, input int sig);
    logic [31:0] v;
    v = 'x;
    if (dut == 0) begin
      case (sig)
        S_WP:    v = 32'(wr_ptr);
        S_TA:    v = 32'(trig_addr);
        S_SA:    v = 32'(start_addr);
        S_WRAP:  v = 32'(wrap);
        S_BUSY:  v = 32'(busy);
        S_DONE:  v = 32'(done);
        S_RD:    v = 32'(rd_data);
        S_WCNT:  v = 32'(wrap_cnt);
        default: v = 'x;
      endcase
    end else begin
      case (sig)
        S_WP:    v = 32'(wr_ptr0);
        S_TA:    v = 32'(trig_addr0);
        S_SA:    v = 32'(start_addr0);
        S_WRAP:  v = 32'(wrap0);
        S_BUSY:  v = 32'(busy0);
        S_DONE:  v = 32'(done0);
        S_RD:    v = 32'(rd_data0);
        default: v = 'x;
      endcase
    end
    return v;
  endfunction

  always @(posedge clk) begin
    rd_req0_d <= rd_req0;
    rd_req1_d <= rd_req1;
  end

  always @(negedge clk) begin
    if (wrap === 1'b1) wrap_cnt++;
    while (stat_q.size() > 0) begin
      mon_s = stat_q.pop_front();
      check(mon_s.name, actual(mon_s.dut, mon_s.sig), 32'(mon_s.exp));
    end
    if (rd_req0_d) begin
      if (rdq0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd0_underflow: got read with no expected value");
      end else begin
        check("rd0", 32'(rd_data), 32'(rdq0.pop_front()));
      end
    end
    if (rd_req1_d) begin
      if (rdq1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd1_underflow: got read with no expected value");
      end else begin
        check("rd1", 32'(rd_data0), 32'(rdq1.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_s(input string n, input int dut, input int sig,
                          input int e);
    stat_q.push_back('{n, dut, sig, e});
  endtask

  task automatic sample(input int v, input bit t);
    din       = DW'(v);
    din_valid = 1'b1;
    trig      = t;
    tick();
    din_valid = 1'b0;
    trig      = 1'b0;
  endtask

  task automatic rd0(input int addr, input int e);
    rd_addr = AW'(addr);
    rd_req0 = 1'b1;
    rdq0.push_back(e);
    tick();
    rd_req0 = 1'b0;
  endtask

  task automatic rd1(input int addr, input int e);
    rd_addr0 = AW'(addr);
    rd_req1  = 1'b1;
    rdq1.push_back(e);
    tick();
    rd_req1  = 1'b0;
  endtask

  // Memory contents at address a after the first capture (values 5..20).
  function automatic int old1(input int a);
    return (a >= 5) ? a : a + 16;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int a;
    rst_n = 1'b0;
    arm = 1'b0; din = '0; din_valid = 1'b0; trig = 1'b0; rd_addr = '0;
    arm0 = 1'b0; din0 = '0; din_valid0 = 1'b0; trig0 = 1'b0; rd_addr0 = '0;

    // Reset state
    tick();
    tick();
    expect_s("rst_wr_ptr", 0, S_WP, 0);
    expect_s("rst_trig_addr", 0, S_TA, 0);
    expect_s("rst_start_addr", 0, S_SA, 0);
    expect_s("rst_wrap", 0, S_WRAP, 0);
    expect_s("rst_busy", 0, S_BUSY, 0);
    expect_s("rst_done", 0, S_DONE, 0);
    expect_s("rst_rd_data", 0, S_RD, 0);
    expect_s("rst0_busy", 1, S_BUSY, 0);
    rst_n = 1'b1;
    tick();

    // Basic capture, trigger on value 9
    arm = 1'b1; tick(); arm = 1'b0;
    expect_s("t1_arm_wr_ptr", 0, S_WP, 0);
    expect_s("t1_arm_busy", 0, S_BUSY, 1);
    expect_s("t1_arm_done", 0, S_DONE, 0);
    for (int v = 0; v <= 20; v++) begin
      sample(v, v == 9);
      if (v == 9)  expect_s("t1_trig_addr", 0, S_TA, 9);
      if (v == 19) begin
        expect_s("t1_pre_done", 0, S_DONE, 0);
        expect_s("t1_pre_busy", 0, S_BUSY, 1);
      end
      if (v == 20) begin
        expect_s("t1_done", 0, S_DONE, 1);
        expect_s("t1_busy", 0, S_BUSY, 0);
        expect_s("t1_start_addr", 0, S_SA, 5);
        expect_s("t1_wr_ptr", 0, S_WP, 5);
      end
    end
    // Samples offered in DONE must not be stored
    sample(99, 1'b1);
    sample(98, 1'b0);
    expect_s("t1_hold_wr_ptr", 0, S_WP, 5);
    expect_s("t1_hold_trig_addr", 0, S_TA, 9);
    expect_s("t1_hold_start_addr", 0, S_SA, 5);
    expect_s("t1_hold_done", 0, S_DONE, 1);
    for (int i = 0; i < 16; i++) rd0((5 + i) % 16, 5 + i);

    // Trigger in PRE ignored; reads at the write address return old data
    arm = 1'b1; tick(); arm = 1'b0;
    for (int v = 0; v <= 17; v++) begin
      rd_addr = AW'(v % 16);
      rd_req0 = 1'b1;
      rdq0.push_back((v < 16) ? old1(v) : 100 + v - 16);
      sample(100 + v, (v == 2) || (v == 6));
      rd_req0 = 1'b0;
      if (v == 2) begin
        expect_s("t2_pre_trig_ignored", 0, S_TA, 9);
        expect_s("t2_pre_busy", 0, S_BUSY, 1);
        expect_s("t2_pre_done", 0, S_DONE, 0);
      end
      if (v == 6) expect_s("t2_trig_addr", 0, S_TA, 6);
      if (v == 16) expect_s("t2_pre_final_done", 0, S_DONE, 0);
      if (v == 17) begin
        expect_s("t2_done", 0, S_DONE, 1);
        expect_s("t2_start_addr", 0, S_SA, 2);
        expect_s("t2_wr_ptr", 0, S_WP, 2);
      end
    end

    // Arm in POST after 3 post samples; arm beats a same-cycle write+trig
    arm = 1'b1; tick(); arm = 1'b0;
    for (int v = 0; v <= 6; v++) begin
      sample(200 + v, v == 4);
      if (v == 4) expect_s("t3_trig_addr", 0, S_TA, 4);
    end
    expect_s("t3_post_busy", 0, S_BUSY, 1);
    expect_s("t3_post_wr_ptr", 0, S_WP, 7);
    arm = 1'b1; din = DW'(777); din_valid = 1'b1; trig = 1'b1;
    tick();
    arm = 1'b0; din_valid = 1'b0; trig = 1'b0;
    expect_s("t3_rearm_wr_ptr", 0, S_WP, 0);
    expect_s("t3_rearm_busy", 0, S_BUSY, 1);
    expect_s("t3_rearm_done", 0, S_DONE, 0);
    expect_s("t3_rearm_trig_addr", 0, S_TA, 4);
    sample(300, 1'b1);
    expect_s("t3_pre_trig_addr", 0, S_TA, 4);
    expect_s("t3_pre_wr_ptr", 0, S_WP, 1);
    sample(301, 1'b0);
    expect_s("t3_pre_wr_ptr2", 0, S_WP, 2);

    // Reset mid-PRE with a sample offered on the reset edge
    rst_n = 1'b0; din = DW'(999); din_valid = 1'b1;
    tick();
    expect_s("t4_wr_ptr", 0, S_WP, 0);
    expect_s("t4_trig_addr", 0, S_TA, 0);
    expect_s("t4_start_addr", 0, S_SA, 0);
    expect_s("t4_wrap", 0, S_WRAP, 0);
    expect_s("t4_busy", 0, S_BUSY, 0);
    expect_s("t4_done", 0, S_DONE, 0);
    expect_s("t4_rd_data", 0, S_RD, 0);
    rst_n = 1'b1; din_valid = 1'b0;
    rd0(1, 301);
    rd0(2, 202);
    rd0(0, 300);
    // IDLE ignores samples
    sample(555, 1'b1);
    sample(556, 1'b0);
    expect_s("t4_idle_wr_ptr", 0, S_WP, 0);
    expect_s("t4_idle_busy", 0, S_BUSY, 0);
    rd0(0, 300);

    // 40 samples in ARMED without a trigger
    arm = 1'b1; tick(); arm = 1'b0;
    wrap_cnt = 0;
    a = 0;
    for (int i = 0; i < 44; i++) begin
      sample(400 + i, 1'b0);
      expect_s($sformatf("t5_wrap_%0d", i), 0, S_WRAP, (a == 15) ? 1 : 0);
      a = (a + 1) % 16;
    end
    expect_s("t5_busy", 0, S_BUSY, 1);
    expect_s("t5_done", 0, S_DONE, 0);
    expect_s("t5_wrap_count", 0, S_WCNT, 2);

    // PRE_TRIG = 0: trigger on the very first sample
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    expect_s("t6_arm_busy", 1, S_BUSY, 1);
    expect_s("t6_arm_wr_ptr", 1, S_WP, 0);
    for (int v = 0; v < 16; v++) begin
      din0 = DW'(50 + v); din_valid0 = 1'b1; trig0 = (v == 0);
      tick();
      din_valid0 = 1'b0; trig0 = 1'b0;
      if (v == 0) expect_s("t6_trig_addr", 1, S_TA, 0);
      if (v == 14) begin
        expect_s("t6_pre_done", 1, S_DONE, 0);
        expect_s("t6_pre_busy", 1, S_BUSY, 1);
      end
      if (v == 15) begin
        expect_s("t6_done", 1, S_DONE, 1);
        expect_s("t6_busy", 1, S_BUSY, 0);
        expect_s("t6_start_addr", 1, S_SA, 0);
        expect_s("t6_wr_ptr", 1, S_WP, 0);
        expect_s("t6_wrap", 1, S_WRAP, 1);
      end
    end
    rd1(0, 50);
    rd1(15, 65);
    rd1(7, 57);

    // Let the monitor drain, then confirm nothing was left unchecked
    tick();
    tick();
    check("drain_rdq0", 32'(rdq0.size()), 32'd0);
    check("drain_rdq1", 32'(rdq1.size()), 32'd0);
    check("drain_stat_q", 32'(stat_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
